// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch core.
// Latency: n/a (types only); backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    ADJ   = 2'd2
  } sw_state_t;

  localparam int MIN_TENS_W = 4;
  localparam int MIN_ONES_W = 4;
  localparam int SEC_TENS_W = 3;
  localparam int SEC_ONES_W = 4;
  localparam int SEC_MOD    = 60;

endpackage

// File: rtl/stopwatch_if.sv
// Tick/control inputs and display-side outputs of the stopwatch core.
// Latency: n/a (wiring only); backpressure: none, strobes are fire-and-forget.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic                  tick_1hz;
  logic                  tick_2hz;
  logic                  tick_4hz;
  logic                  pause_p;
  logic                  clr_p;
  logic                  adj;
  logic                  sel;
  logic [MIN_TENS_W-1:0] min_tens;
  logic [MIN_ONES_W-1:0] min_ones;
  logic [SEC_TENS_W-1:0] sec_tens;
  logic [SEC_ONES_W-1:0] sec_ones;
  logic                  blank_min;
  logic                  blank_sec;
  logic                  rollover;

  modport master (
    output tick_1hz, tick_2hz, tick_4hz, pause_p, clr_p, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, rollover
  );

  modport slave (
    input  tick_1hz, tick_2hz, tick_4hz, pause_p, clr_p, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, rollover
  );

endinterface

// File: rtl/stopwatch_bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD with clear priority; wrap = inc at MOD-1 (combinational from state).
// Latency: digits update on the edge that samples inc/clr; backpressure: none.
module bcd_mod_counter #(
  parameter int MOD    = 60,
  parameter int TENS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [TENS_W-1:0] tens,
  output logic [3:0]        ones,
  output logic              wrap
);

  localparam logic [TENS_W-1:0] TOP_TENS = TENS_W'((MOD - 1) / 10);
  localparam logic [3:0]        TOP_ONES = 4'((MOD - 1) % 10);
  localparam logic [TENS_W-1:0] ONE_T    = TENS_W'(1);

  logic at_top;

  assign at_top = (tens == TOP_TENS) && (ones == TOP_ONES);
  assign wrap   = inc && at_top;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens <= '0;
      ones <= '0;
    end else if (clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (at_top) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == 4'd9) begin
        ones <= '0;
        tens <= tens + ONE_T;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with RUN/PAUSE/ADJ modes and adjust blink; STOPWATCH_SAT_STOP_EN stops at the top count.
// Latency: strobe at edge N shows in registered outputs after edge N; backpressure: none.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MIN_MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  stopwatch_if.slave sw
);

`ifdef STOPWATCH_SAT_STOP_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [MIN_TENS_W-1:0] MT_TOP = MIN_TENS_W'((MIN_MOD - 1) / 10);
  localparam logic [MIN_ONES_W-1:0] MO_TOP = MIN_ONES_W'((MIN_MOD - 1) % 10);

  sw_state_t             state, state_nx;
  logic                  paused, paused_nx;
  logic                  blink, blink_nx;
  logic                  blank_min_nx, blank_sec_nx;
  logic                  blank_min_q, blank_sec_q, rollover_q;
  logic                  sat_hit;

  logic [MIN_TENS_W-1:0] min_tens;
  logic [MIN_ONES_W-1:0] min_ones;
  logic [SEC_TENS_W-1:0] sec_tens;
  logic [SEC_ONES_W-1:0] sec_ones;
  logic                  sec_wrap, min_wrap;
  logic                  sec_inc, min_inc, roll_nx;
  logic                  min_top, at_top, pre_top;

  assign min_top = (min_tens == MT_TOP) && (min_ones == MO_TOP);
  assign at_top  = min_top && (sec_tens == 3'd5) && (sec_ones == 4'd9);
  assign pre_top = min_top && (sec_tens == 3'd5) && (sec_ones == 4'd8);

  // In saturating builds the top count freezes: the tick is swallowed instead of wrapping.
  assign sec_inc = ((state == RUN) && sw.tick_1hz && !(SAT_EN && at_top)) ||
                   ((state == ADJ) && sw.tick_2hz && sw.sel);
  assign min_inc = ((state == RUN) && sec_wrap) ||
                   ((state == ADJ) && sw.tick_2hz && !sw.sel);
  assign roll_nx = (state == RUN) && !sw.clr_p && sec_wrap && min_wrap;

  bcd_mod_counter #(.MOD(SEC_MOD), .TENS_W(SEC_TENS_W)) u_sec (
    .clk  (clk),
    .rst  (rst),
    .inc  (sec_inc),
    .clr  (sw.clr_p),
    .tens (sec_tens),
    .ones (sec_ones),
    .wrap (sec_wrap)
  );

  bcd_mod_counter #(.MOD(MIN_MOD), .TENS_W(MIN_TENS_W)) u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (min_inc),
    .clr  (sw.clr_p),
    .tens (min_tens),
    .ones (min_ones),
    .wrap (min_wrap)
  );

  always_comb begin
    state_nx     = state;
    paused_nx    = paused ^ sw.pause_p;
    sat_hit      = SAT_EN && (state == RUN) && !sw.clr_p &&
                   (at_top || (sw.tick_1hz && pre_top));
    if (sat_hit) begin
      paused_nx = 1'b1;
    end
    if (sw.adj) begin
      state_nx = ADJ;
    end else if (paused_nx) begin
      state_nx = PAUSE;
    end else begin
      state_nx = RUN;
    end
    // Blink restarts from 0 on every entry into ADJ.
    blink_nx     = ((state == ADJ) && (state_nx == ADJ)) ? (blink ^ sw.tick_4hz) : 1'b0;
    blank_min_nx = (state_nx == ADJ) && blink_nx && !sw.sel;
    blank_sec_nx = (state_nx == ADJ) && blink_nx && sw.sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      paused      <= 1'b0;
      blink       <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
      rollover_q  <= 1'b0;
    end else begin
      state       <= state_nx;
      paused      <= paused_nx;
      blink       <= blink_nx;
      blank_min_q <= blank_min_nx;
      blank_sec_q <= blank_sec_nx;
      rollover_q  <= roll_nx;
    end
  end

  assign sw.min_tens  = min_tens;
  assign sw.min_ones  = min_ones;
  assign sw.sec_tens  = sec_tens;
  assign sw.sec_ones  = sec_ones;
  assign sw.blank_min = blank_min_q;
  assign sw.blank_sec = blank_sec_q;
  assign sw.rollover  = rollover_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core against a seconds-arithmetic reference model.
module tb_stopwatch_core;

  localparam int MM = 60;
`ifdef STOPWATCH_SAT_STOP_EN
  localparam bit M_SAT = 1'b1;
`else
  localparam bit M_SAT = 1'b0;
`endif

  logic clk;
  logic rst;
  stopwatch_if sw_if ();

  stopwatch_core #(.MIN_MOD(MM)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: time as minutes/seconds integers, mode 0=run 1=pause 2=adjust
  int m_min, m_sec, m_mode;
  bit m_paused, m_blink, e_bmin, e_bsec, e_roll;

  logic [17:0] obs;
  assign obs = {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones,
                sw_if.blank_min, sw_if.blank_sec, sw_if.rollover};

  logic [14:0] digs;
  assign digs = obs[17:3];

  function automatic logic [17:0] expv();
    return {4'(m_min / 10), 4'(m_min % 10), 3'(m_sec / 10), 4'(m_sec % 10),
            e_bmin, e_bsec, e_roll};
  endfunction

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_mode = 0;
    m_paused = 0; m_blink = 0; e_bmin = 0; e_bsec = 0; e_roll = 0;
  endtask

  task automatic model_edge(input bit t1, t2, t4, pp, cp, a, s);
    int secs;
    int nmode;
    bit np;
    e_roll = 0;
    if (cp) begin
      m_min = 0; m_sec = 0;
    end else if (m_mode == 0) begin
      if (t1 && !(M_SAT && m_min == MM - 1 && m_sec == 59)) begin
        secs = m_min * 60 + m_sec + 1;
        if (secs == MM * 60) begin
          secs = 0;
          e_roll = 1;
        end
        m_min = secs / 60;
        m_sec = secs % 60;
      end
    end else if (m_mode == 2 && t2) begin
      if (s) m_sec = (m_sec + 1) % 60;
      else   m_min = (m_min + 1) % MM;
    end
    np = m_paused ^ pp;
    if (M_SAT && m_mode == 0 && !cp && m_min == MM - 1 && m_sec == 59) np = 1;
    nmode   = a ? 2 : (np ? 1 : 0);
    m_blink = (m_mode == 2 && nmode == 2) ? (m_blink ^ t4) : 1'b0;
    e_bmin  = (nmode == 2) && m_blink && !s;
    e_bsec  = (nmode == 2) && m_blink && s;
    m_mode   = nmode;
    m_paused = np;
  endtask

  task automatic step(input bit t1, t2, t4, pp, cp);
    sw_if.tick_1hz = t1;
    sw_if.tick_2hz = t2;
    sw_if.tick_4hz = t4;
    sw_if.pause_p  = pp;
    sw_if.clr_p    = cp;
    @(posedge clk);
    model_edge(t1, t2, t4, pp, cp, sw_if.adj, sw_if.sel);
    #1;
    sw_if.tick_1hz = 0;
    sw_if.tick_2hz = 0;
    sw_if.tick_4hz = 0;
    sw_if.pause_p  = 0;
    sw_if.clr_p    = 0;
  endtask

  task automatic go_run();
    if (m_paused) step(0, 0, 0, 1, 0);
  endtask

  // Load a time through adjust mode, then leave in RUN.
  task automatic preload(input int tm, input int ts);
    sw_if.adj = 1; sw_if.sel = 0;
    step(0, 0, 0, 0, 0);
    repeat ((tm - m_min + MM) % MM) step(0, 1, 0, 0, 0);
    sw_if.sel = 1;
    repeat ((ts - m_sec + 60) % 60) step(0, 1, 0, 0, 0);
    sw_if.sel = 0; sw_if.adj = 0;
    step(0, 0, 0, 0, 0);
    go_run();
  endtask

  task automatic test_reset();
    rst = 0;
    sw_if.tick_1hz = 0; sw_if.tick_2hz = 0; sw_if.tick_4hz = 0;
    sw_if.pause_p = 0; sw_if.clr_p = 0; sw_if.adj = 0; sw_if.sel = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL reset_hold: got %h want %h", obs, 18'd0);
    end
    #3 rst = 1;
    step(0, 0, 0, 0, 0);
    total++;
    if (obs !== expv()) begin
      bad++; $display("FAIL reset_release: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_count();
    repeat (61) begin
      step(1, 0, 0, 0, 0);
      total++;
      if (sw_if.rollover !== 1'b0) begin
        bad++; $display("FAIL count_rollover: got %b want 0", sw_if.rollover);
      end
    end
    total++;
    if (obs !== expv()) begin
      bad++; $display("FAIL count_61: got %h want %h", obs, expv());
    end
    total++;
    if (digs !== 15'h081) begin
      bad++; $display("FAIL count_0101: got %h want %h", digs, 15'h081);
    end
  endtask

  task automatic test_wrap();
    preload(59, 58);
    for (int i = 0; i < 4; i++) begin
      step(i != 2, 0, 0, 0, 0);
      total++;
      if (obs !== expv()) begin
        bad++; $display("FAIL wrap_step%0d: got %h want %h", i, obs, expv());
      end
      if (i == 1) begin
        total++;
        if (M_SAT ? (digs !== 15'h2CD9 || sw_if.rollover !== 1'b0)
                  : (digs !== 15'h000 || sw_if.rollover !== 1'b1)) begin
          bad++; $display("FAIL wrap_top: got %h roll=%b", digs, sw_if.rollover);
        end
      end
    end
  endtask

  task automatic test_pause();
    go_run();
    step(0, 0, 0, 1, 0);
    repeat (5) begin
      step(1, 0, 0, 0, 0);
      total++;
      if (obs !== expv()) begin
        bad++; $display("FAIL pause_hold: got %h want %h", obs, expv());
      end
    end
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    total++;
    if (obs !== expv()) begin
      bad++; $display("FAIL pause_resume: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_adj();
    preload(0, 10);
    sw_if.adj = 1; sw_if.sel = 0;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        step(k == 0, k == 2, k[0], 0, 0);
        total++;
        if (obs !== expv()) begin
          bad++; $display("FAIL adj_r%0d_k%0d: got %h want %h", i, k, obs, expv());
        end
      end
    end
    total++;
    if (digs !== 15'h190) begin
      bad++; $display("FAIL adj_0310: got %h want %h", digs, 15'h190);
    end
    sw_if.adj = 0;
    step(0, 0, 1, 0, 0);
    total++;
    if (obs !== expv() || sw_if.blank_min !== 1'b0 || sw_if.blank_sec !== 1'b0) begin
      bad++; $display("FAIL adj_exit: got %h want %h", obs, expv());
    end
    step(1, 0, 0, 0, 0);
    total++;
    if (obs !== expv()) begin
      bad++; $display("FAIL adj_run: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_clr();
    preload(12, 34);
    step(1, 0, 0, 0, 1);
    total++;
    if (obs !== expv() || digs !== 15'h000) begin
      bad++; $display("FAIL clr_tick: got %h want %h", obs, expv());
    end
    step(1, 0, 0, 0, 0);
    total++;
    if (digs !== 15'h001 || obs !== expv()) begin
      bad++; $display("FAIL clr_run: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_async_reset();
    preload(7, 42);
    #3 rst = 0;
    #1;
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL areset_now: got %h want %h", obs, 18'd0);
    end
    #2 rst = 1;
    model_reset();
    step(1, 0, 0, 0, 0);
    total++;
    if (digs !== 15'h001 || obs !== expv()) begin
      bad++; $display("FAIL areset_first: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_random();
    preload(59, 40);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) sw_if.adj = ~sw_if.adj;
      if ($urandom_range(7) == 0)  sw_if.sel = ~sw_if.sel;
      step($urandom_range(2) != 0, $urandom_range(2) == 0, $urandom_range(1) == 0,
           $urandom_range(24) == 0, $urandom_range(59) == 0);
      total++;
      if (obs !== expv()) begin
        bad++; $display("FAIL random_%0d: got %h want %h", i, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_pause();
    test_adj();
    test_clr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Stopwatch timekeeping core, MM:SS in BCD. It consumes the single-cycle tick strobes from the design's clock-enable generator (1 Hz count, 2 Hz adjust, 4 Hz blink) and user control pulses, and it drives the digit and blank signals that feed the display multiplexer. All logic runs on the master clock; ticks are clock enables, never clocks.

## Interface
- `MIN_MOD`, default 60: minutes-field modulus. Legal range 10..100. The seconds modulus is fixed at 60.

Ports:
- `clk`  in  1  master clock
- `rst`  in  1  asynchronous, active-low reset
- `tick_1hz`  in  1  one-cycle count strobe
- `tick_2hz`  in  1  one-cycle adjust strobe
- `tick_4hz`  in  1  one-cycle blink strobe
- `pause_p`  in  1  one-cycle, pre-debounced pulse; toggles run/pause
- `clr_p`  in  1  one-cycle, pre-debounced pulse; clears time to 00:00
- `adj`  in  1  level; 1 selects adjust mode
- `sel`  in  1  level; field to adjust, 0 = minutes, 1 = seconds
- `min_tens`  out  4  minutes tens digit, BCD
- `min_ones`  out  4  minutes ones digit, BCD
- `sec_tens`  out  3  seconds tens digit, 0..5
- `sec_ones`  out  4  seconds ones digit, BCD
- `blank_min`  out  1  1 = blank the minutes digits
- `blank_sec`  out  1  1 = blank the seconds digits
- `rollover`  out  1  one-cycle pulse when time wraps to 00:00 while counting

## Operation
- States:
  - RUN: counts on `tick_1hz`.
  - PAUSE: holds the time.
  - ADJ: edits the field selected by `sel`.
- A `paused` flag records whether the core returns to RUN or PAUSE when it leaves ADJ.
- Transitions:
  - `adj`=1 moves any state to ADJ on the next edge.
  - `adj`=0 in ADJ moves to PAUSE if `paused`=1, else to RUN.
  - `pause_p` toggles `paused` in every state. In RUN/PAUSE the state follows `paused` on the same edge.
- RUN counting, on each `tick_1hz`:
  - Seconds increment.
  - At 59, seconds wrap to 00 and carry into minutes.
  - Minutes wrap from MIN_MOD-1 to 00. A wrap of the full time to 00:00 asserts `rollover`.
- ADJ editing, on each `tick_2hz`:
  - The selected field increments by 1 and wraps at its modulus.
  - There is no carry into the other field. `rollover` is not asserted.
  - `tick_1hz` is ignored.
- Blink:
  - A `blink` flag toggles on `tick_4hz` while in ADJ. It is forced to 0 outside ADJ.
  - `blank_min` = ADJ & `blink` & ~`sel`.
  - `blank_sec` = ADJ & `blink` & `sel`.
- Priority on any edge: `rst` > `clr_p` > increment.
  - `clr_p` zeroes all digits and drops a coincident tick.
  - `clr_p` leaves the state and `paused` unchanged.
- Digits are always valid BCD. No illegal digit value is ever output.

## Timing
- Every output is registered.
- Latency: a strobe sampled at edge N is reflected in the digits after edge N. `rollover` is high for exactly the cycle after that edge.
- Reset values:
  - All digits 0, `blank_*` 0, `rollover` 0.
  - State RUN, `paused` 0, `blink` 0.
- `rst` asserted mid-count zeroes everything immediately, with no clock edge required. Release is synchronous to the next `clk` edge.
- Coincident ticks in ADJ: only the `tick_2hz` increment applies.
- Coincident `pause_p` and `adj` rising: the core enters ADJ and `paused` toggles.

## Configuration
- `STOPWATCH_SAT_STOP_EN`
  - Defined: reaching (MIN_MOD-1):59 in RUN forces `paused`=1 and the state to PAUSE. The next `tick_1hz` is ignored and the time holds; `rollover` never asserts. ADJ wrapping is unaffected.
  - Undefined: the time wraps to 00:00 with a `rollover` pulse.

## Structure
- `stopwatch_pkg` holds:
  - State enum `sw_state_t` (RUN, PAUSE, ADJ).
  - Digit width constants.
  - `SEC_MOD` = 60.
- Sub-module `bcd_mod_counter`: two-digit BCD counter with parameter MOD and inputs `inc`/`clr`. It outputs the tens/ones digits and a registered-compatible `wrap` (inc at MOD-1). It is instantiated once for seconds and once for minutes. The minutes `inc` is the seconds `wrap` in RUN, or the adjust increment in ADJ.

## Test plan
- Reset release, then 61 `tick_1hz` -> 01:01, `rollover` never high.
- Preload 59:58 via ADJ, then RUN and 2 `tick_1hz`:
  - Macro off -> 00:00, with `rollover` high for exactly 1 cycle.
  - Macro on -> holds 59:59, state PAUSE.
- `pause_p`, then 5 `tick_1hz` -> time unchanged. A second `pause_p` plus 1 tick -> +1 second.
- At 00:10, `adj`=1 and `sel`=0, then 3 `tick_2hz` plus interleaved `tick_1hz` -> 03:10. `blank_min` toggles on each `tick_4hz` and `blank_sec` stays 0. `adj`=0 -> returns to RUN with blink cleared.
- At 12:34, `clr_p` coincident with `tick_1hz` -> 00:00 the next cycle, with the state still RUN.
- `rst` pulled low between clock edges at 07:42 -> all outputs 0 before the next edge. After release, the first tick -> 00:01.
